jlsemi_util_clkdiv_checker: RTL and testbench
=============================================

Name: jlsemi_util_clkdiv_checker

Overview:
Monitors a divided clock produced by an even clock divider running from the same source clock. Measures the high and low half-period lengths and the phase of the first rising edge in source-clock cycles. Compares the measurements against the divider configuration (DIV_N, DIV_PHASE_CNT) and reports lock or a sticky error. Sits beside each divider instance and is read by the capture-path status registers and DFT/bring-up logic.

Parameters:
SYNC_STAGE, 2, synchronizer flops on div_clk_in (2..4)
PHASE_OFS, 3, fixed pipeline offset added to expected phase (toggle flop + sync + edge detect)
LOCK_CNT, 4, consecutive good full periods needed to declare lock (1..15)
TIMEOUT, 1023, source cycles without a div_clk_in edge before timeout error (10-bit)

Ports:
clk_in  input  1  source clock; same clock that feeds the divider
rst_in  input  1  asynchronous reset, active-high
en_in  input  1  check enable; 0 forces IDLE and clears status
clr_err_in  input  1  one-cycle pulse; clears sticky error and returns to WAIT_EDGE
sync_in  input  1  one-cycle pulse marking divider counter restart (phase origin)
div_clk_in  input  1  divided clock under test
DIV_N  input  9  divider ratio, quasi-static
DIV_PHASE_CNT  input  9  divider toggle count, quasi-static
lock_o  output  1  measurement matched for LOCK_CNT consecutive periods
err_o  output  1  sticky error flag
err_code_o  output  2  0 none, 1 half-period mismatch, 2 phase mismatch, 3 timeout/config
meas_high_o  output  10  last measured high time (cycles)
meas_low_o  output  10  last measured low time (cycles)
meas_vld_o  output  1  one-cycle pulse when a full period (low+high) completes

Behaviour:
- Reset: all outputs 0; FSM IDLE; counters 0; sync chain 0.
- div_clk_in passes through SYNC_STAGE flops, then a 1-flop edge detector; rise/fall pulses are 1-cycle and come SYNC_STAGE+1 cycles after the actual edge.
- Expected half-period EXP_H = DIV_N[8:1]. Config invalid if DIV_N < 2 or DIV_N[0]=1 or DIV_PHASE_CNT >= EXP_H.
- Half counter (10 bit, saturating at 1023): reset to 1 on each rise/fall, else increments. On fall, latch into meas_high_o; on rise, latch into meas_low_o and pulse meas_vld_o in the same cycle.
- Phase counter (10 bit, saturating): cleared to 0 by sync_in, increments each cycle until the first rise after sync_in, then freezes. Expected value is DIV_PHASE_CNT + PHASE_OFS. Checked once per sync_in.
- FSM states:
  IDLE: en_in=0. lock_o=0, err_o=0, err_code_o=0. When en_in=1, go to WAIT_EDGE; if config invalid, go to ERROR with code 3 instead.
  WAIT_EDGE: discard the partial first half-period. On the first rise, go to MEASURE with the good-count at 0.
  MEASURE: on every fall or rise, compare the latched half with EXP_H; a mismatch goes to ERROR code 1. On each rise with both halves good, good-count++. When good-count reaches LOCK_CNT, go to LOCKED with lock_o=1.
  LOCKED: keeps checking every half-period; a mismatch goes to ERROR code 1, lock_o=0.
  ERROR: err_o=1 and err_code_o hold until clr_err_in (go to WAIT_EDGE) or en_in=0 (go to IDLE).
- Phase check: evaluated in MEASURE and LOCKED when the first rise after sync_in occurs. A mismatch goes to ERROR code 2. A sync_in with no subsequent rise is covered by the timeout.
- Timeout: in WAIT_EDGE, MEASURE or LOCKED, half counter reaching TIMEOUT goes to ERROR code 3.
- Simultaneous events, in priority order:
  - en_in=0 beats everything.
  - clr_err_in beats a new error in the same cycle.
  - Error codes are prioritised 3 > 2 > 1 when they fire together.
  - sync_in coinciding with a rise starts the phase count at 0; that rise is not the phase edge.
- DIV_N or DIV_PHASE_CNT changing while enabled is not tracked; software must toggle en_in.
- rst_in asserted mid-operation: everything returns to reset values immediately (asynchronous).

Decomposition:
- Shared package jlsemi_util_clkdiv_pkg holds:
  - FSM state encoding (IDLE, WAIT_EDGE, MEASURE, LOCKED, ERROR).
  - ERR_NONE/ERR_HALF/ERR_PHASE/ERR_TMO code constants.
  - The counter width constant 10.
- One sub-module, jlsemi_util_sync_edge_det: SYNC_STAGE synchronizer plus rise/fall pulse outputs. It is reusable by other clock monitors.

Test Plan:
- DIV_N=8, DIV_PHASE_CNT=0, LOCK_CNT=4, en_in=1 with an ideal divider model -> meas_high_o=meas_low_o=4 each period; lock_o=1 after 4 rising edges following the first; err_o=0.
- DIV_N=8, sync_in at divider restart, DIV_PHASE_CNT=2 with model toggling at cnt==2 -> phase counter=5 (2+PHASE_OFS); no error. Model toggling at cnt==3 -> err_o=1, err_code_o=2.
- Locked at DIV_N=10, then stretch one high phase to 6 cycles -> on that fall err_o=1, err_code_o=1, lock_o=0. clr_err_in -> WAIT_EDGE, relock after LOCK_CNT periods.
- div_clk_in held at 0 after lock -> err_code_o=3 exactly TIMEOUT cycles after the last edge.
- DIV_N=7 (odd) or DIV_N=1 with en_in rising -> ERROR with code 3 on the next cycle. en_in=0 -> all status 0.
- rst_in pulsed while LOCKED at DIV_N=16 -> all outputs 0 without a clock edge. After release, full reacquisition gives lock_o=1 and meas_high_o=8.

Source files
------------

// File: rtl/jlsemi_util_clkdiv_pkg.sv
// Shared types and constants for the divided-clock checker.
// Holds the FSM encoding, error codes and the configuration sanity check.
package jlsemi_util_clkdiv_pkg;

    localparam int CNT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_EDGE = 3'd1,
        ST_MEASURE   = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_HALF  = 2'd1;
    localparam logic [1:0] ERR_PHASE = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    // A divider setting is only checkable if it is even, at least 2, and
    // its toggle point lies inside the first half-period.
    function automatic logic cfg_invalid(input logic [8:0] div_n,
                                         input logic [8:0] phase_cnt);
        return (div_n < 9'd2) || div_n[0] || (phase_cnt >= {1'b0, div_n[8:1]});
    endfunction

endpackage

// File: rtl/jlsemi_util_sync_edge_det.sv
// Synchronizes an asynchronous-looking level into clk_in and emits registered
// one-cycle rise/fall pulses, SYNC_STAGE+1 cycles after the input edge.
module jlsemi_util_sync_edge_det #(
    parameter int SYNC_STAGE = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGE-1:0] sync_q;
    logic                  last_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGE-2:0], d_in};
            last_q <= sync_q[SYNC_STAGE-1];
            rise_o <= sync_q[SYNC_STAGE-1] & ~last_q;
            fall_o <= ~sync_q[SYNC_STAGE-1] & last_q;
        end
    end

endmodule

// File: rtl/jlsemi_util_clkdiv_checker.sv
// Checks a divided clock against its divider configuration: half-period
// lengths, first-rise phase after a divider restart, and edge activity.
module jlsemi_util_clkdiv_checker
    import jlsemi_util_clkdiv_pkg::*;
#(
    parameter int SYNC_STAGE = 2,
    parameter int PHASE_OFS  = 3,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             clr_err_in,
    input  logic             sync_in,
    input  logic             div_clk_in,
    input  logic [8:0]       DIV_N,
    input  logic [8:0]       DIV_PHASE_CNT,
    output logic             lock_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] meas_high_o,
    output logic [CNT_W-1:0] meas_low_o,
    output logic             meas_vld_o,
    output logic [2:0]       dbg_state_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO_W   = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_M1 = 4'(LOCK_CNT - 1);

    logic             edge_rise;
    logic             edge_fall;
    logic [CNT_W-1:0] half_cnt;
    logic [CNT_W-1:0] phase_cnt;
    logic             phase_arm;
    logic [3:0]       good_cnt;
    logic [3:0]       good_d;
    state_t           state_q;
    state_t           state_d;
    logic [1:0]       code_q;
    logic [1:0]       code_d;

    logic [CNT_W-1:0] exp_h;
    logic [CNT_W-1:0] exp_phase;
    logic             cfg_bad;
    logic             tmo_hit;
    logic             half_bad;
    logic             phase_bad;
    logic [1:0]       err_sel;
    logic             measuring;

    jlsemi_util_sync_edge_det #(
        .SYNC_STAGE(SYNC_STAGE)
    ) u_edge (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (div_clk_in),
        .rise_o (edge_rise),
        .fall_o (edge_fall)
    );

    assign exp_h     = {2'b00, DIV_N[8:1]};
    assign exp_phase = {1'b0, DIV_PHASE_CNT} + CNT_W'(PHASE_OFS);
    assign cfg_bad   = cfg_invalid(DIV_N, DIV_PHASE_CNT);
    assign measuring = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);

    // meas_vld_o is a one-cycle strobe with no ready: a consumer that misses
    // it still finds the values held on meas_high_o/meas_low_o.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            half_cnt    <= '0;
            meas_high_o <= '0;
            meas_low_o  <= '0;
            meas_vld_o  <= 1'b0;
        end else begin
            meas_vld_o <= 1'b0;
            // Restart on leaving IDLE or on clear so a quiet idle period is
            // not mistaken for a dead divider.
            if (edge_rise || edge_fall || (state_q == ST_IDLE) || clr_err_in) begin
                half_cnt <= 10'd1;
            end else if (half_cnt != CNT_MAX) begin
                half_cnt <= half_cnt + 10'd1;
            end
            if (en_in && edge_fall) begin
                meas_high_o <= half_cnt;
            end
            if (en_in && edge_rise) begin
                meas_low_o <= half_cnt;
                meas_vld_o <= measuring;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            phase_cnt <= '0;
            phase_arm <= 1'b0;
        end else if (!en_in) begin
            phase_arm <= 1'b0;
        end else if (sync_in) begin
            phase_cnt <= '0;
            phase_arm <= 1'b1;
        end else if (phase_arm) begin
            if (edge_rise) begin
                phase_arm <= 1'b0;
            end else if (phase_cnt != CNT_MAX) begin
                phase_cnt <= phase_cnt + 10'd1;
            end
        end
    end

    assign tmo_hit   = (half_cnt >= TMO_W);
    assign half_bad  = (edge_rise || edge_fall) && (half_cnt != exp_h);
    assign phase_bad = edge_rise && phase_arm && !sync_in && (phase_cnt != exp_phase);

    always_comb begin
        err_sel = ERR_NONE;
        if (tmo_hit) begin
            err_sel = ERR_TMO;
        end else if (phase_bad) begin
            err_sel = ERR_PHASE;
        end else if (half_bad) begin
            err_sel = ERR_HALF;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            code_q   <= ERR_NONE;
            good_cnt <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            good_cnt <= good_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        good_d  = good_cnt;
        case (state_q)
            ST_IDLE: begin
                code_d = ERR_NONE;
                good_d = '0;
                if (en_in) begin
                    if (cfg_bad) begin
                        state_d = ST_ERROR;
                        code_d  = ERR_TMO;
                    end else begin
                        state_d = ST_WAIT_EDGE;
                    end
                end
            end
            ST_WAIT_EDGE: begin
                if (tmo_hit) begin
                    state_d = ST_ERROR;
                    code_d  = ERR_TMO;
                end else if (edge_rise) begin
                    state_d = ST_MEASURE;
                    good_d  = '0;
                end
            end
            ST_MEASURE: begin
                if (err_sel != ERR_NONE) begin
                    state_d = ST_ERROR;
                    code_d  = err_sel;
                end else if (edge_rise) begin
                    good_d = good_cnt + 4'd1;
                    if (good_cnt == LOCK_M1) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (err_sel != ERR_NONE) begin
                    state_d = ST_ERROR;
                    code_d  = err_sel;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
                code_d  = ERR_NONE;
                good_d  = '0;
            end
        endcase

        // Clear overrides any error raised in the same cycle; disable
        // overrides everything.
        if (clr_err_in && (state_q != ST_IDLE)) begin
            good_d = '0;
            if (cfg_bad) begin
                state_d = ST_ERROR;
                code_d  = ERR_TMO;
            end else begin
                state_d = ST_WAIT_EDGE;
                code_d  = ERR_NONE;
            end
        end
        if (!en_in) begin
            state_d = ST_IDLE;
            code_d  = ERR_NONE;
            good_d  = '0;
        end
    end

    assign lock_o      = (state_q == ST_LOCKED);
    assign err_o       = (state_q == ST_ERROR);
    assign err_code_o  = code_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jlsemi_util_clkdiv_checker.sv
// Directed bench for the divided-clock checker: an ideal divider model drives
// div_clk_in/sync_in, a scoreboard checks each completed period measurement.
module tb_jlsemi_util_clkdiv_checker;

    localparam int SYNC_STAGE = 2;
    localparam int PHASE_OFS  = 3;
    localparam int LOCK_CNT   = 4;
    localparam int TIMEOUT    = 1023;

    logic       clk_in;
    logic       rst_in;
    logic       en_in;
    logic       clr_err_in;
    logic       sync_in;
    logic       div_clk_in;
    logic [8:0] div_n;
    logic [8:0] div_phase_cnt;
    logic       lock_o;
    logic       err_o;
    logic [1:0] err_code_o;
    logic [9:0] meas_high_o;
    logic [9:0] meas_low_o;
    logic       meas_vld_o;
    logic [2:0] dbg_state_o;

    int n_checks;
    int n_errors;
    int cyc;

    // divider model state
    bit m_run;
    bit m_sync;
    bit m_stretch;
    bit m_stop_fall;
    bit m_fall_seen;
    int m_n;
    int m_p;
    int m_h;
    int m_cnt;
    int m_rises;
    int m_fall_cyc;

    // scoreboard
    logic [19:0] exp_q[$];
    bit          mon_on;

    jlsemi_util_clkdiv_checker #(
        .SYNC_STAGE(SYNC_STAGE),
        .PHASE_OFS (PHASE_OFS),
        .LOCK_CNT  (LOCK_CNT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .en_in         (en_in),
        .clr_err_in    (clr_err_in),
        .sync_in       (sync_in),
        .div_clk_in    (div_clk_in),
        .DIV_N         (div_n),
        .DIV_PHASE_CNT (div_phase_cnt),
        .lock_o        (lock_o),
        .err_o         (err_o),
        .err_code_o    (err_code_o),
        .meas_high_o   (meas_high_o),
        .meas_low_o    (meas_low_o),
        .meas_vld_o    (meas_vld_o),
        .dbg_state_o   (dbg_state_o)
    );

    // clock / cycle counter
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_in);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ideal even divider: counter 0..N-1, toggle flop flips after cnt==P and
    // cnt==P+N/2, sync_in high while the counter sits at 0.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (m_run) begin
                if (m_stretch && div_clk_in && (m_cnt == m_p + m_h)) begin
                    m_stretch = 1'b0;
                    sync_in   = 1'b0;
                end else begin
                    if ((m_cnt == m_p) || (m_cnt == m_p + m_h)) begin
                        div_clk_in = ~div_clk_in;
                        if (div_clk_in) begin
                            m_rises++;
                        end else begin
                            m_fall_seen = 1'b1;
                            if (m_stop_fall) begin
                                m_run       = 1'b0;
                                m_stop_fall = 1'b0;
                                m_fall_cyc  = cyc;
                            end
                        end
                    end
                    m_cnt   = (m_cnt == m_n - 1) ? 0 : m_cnt + 1;
                    sync_in = m_sync && (m_cnt == 0);
                end
            end else begin
                sync_in = 1'b0;
            end
        end
    end

    // monitor: compare each completed period against the expected queue
    initial begin
        logic [19:0] exp_v;
        forever begin
            @(negedge clk_in);
            if (mon_on && meas_vld_o && (exp_q.size() > 0)) begin
                exp_v = exp_q.pop_front();
                chk("sb_period", {12'd0, meas_high_o, meas_low_o}, {12'd0, exp_v});
            end
        end
    end

    task automatic sb_run(input int n_per, input int h, input int budget);
        for (int i = 0; i < n_per; i++) exp_q.push_back({10'(h), 10'(h)});
        mon_on = 1'b1;
        for (int i = 0; (i < budget) && (exp_q.size() > 0); i++) @(negedge clk_in);
        chk("sb_drain", exp_q.size(), 0);
        exp_q.delete();
        mon_on = 1'b0;
    endtask

    task automatic start_run(input int n, input int p, input int mp, input bit sy);
        @(negedge clk_in);
        en_in      = 1'b0;
        m_run      = 1'b0;
        div_clk_in = 1'b0;
        sync_in    = 1'b0;
        repeat (8) @(negedge clk_in);
        div_n         = 9'(n);
        div_phase_cnt = 9'(p);
        m_n         = n;
        m_p         = mp;
        m_h         = n / 2;
        m_cnt       = 0;
        m_sync      = sy;
        m_rises     = 0;
        m_stretch   = 1'b0;
        m_stop_fall = 1'b0;
        m_run       = 1'b1;
        en_in       = 1'b1;
    endtask

    task automatic wait_lock(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (lock_o) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_err(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (err_o) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic cfg_case(input string name, input int n, input int p);
        @(negedge clk_in);
        div_n         = 9'(n);
        div_phase_cnt = 9'(p);
        en_in         = 1'b1;
        @(negedge clk_in);
        chk({name, "_err"}, err_o, 1);
        chk({name, "_code"}, err_code_o, 3);
        en_in = 1'b0;
        @(negedge clk_in);
        chk({name, "_off_err"}, err_o, 0);
        chk({name, "_off_code"}, err_code_o, 0);
    endtask

    initial begin
        bit got;
        n_checks      = 0;
        n_errors      = 0;
        rst_in        = 1'b1;
        en_in         = 1'b0;
        clr_err_in    = 1'b0;
        sync_in       = 1'b0;
        div_clk_in    = 1'b0;
        div_n         = 9'd8;
        div_phase_cnt = 9'd0;
        m_run         = 1'b0;
        m_fall_seen   = 1'b0;
        mon_on        = 1'b0;

        // reset state
        #25;
        chk("rst_status", {lock_o, err_o, err_code_o}, 0);
        chk("rst_meas", {meas_high_o, meas_low_o, meas_vld_o}, 0);
        chk("rst_state", dbg_state_o, 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // DIV_N=8, phase 0: lock on the 5th rise (first rise + LOCK_CNT)
        start_run(8, 0, 0, 1'b0);
        wait_lock(200, got);
        chk("t1_lock", got, 1);
        chk("t1_rises", m_rises, 5);
        chk("t1_err", err_o, 0);
        sb_run(4, 4, 100);

        // phase check with sync every period: toggle at cnt 2 matches 2+3
        start_run(8, 2, 2, 1'b1);
        wait_lock(200, got);
        chk("t2_lock", got, 1);
        repeat (40) @(negedge clk_in);
        chk("t2_err_after", err_o, 0);
        chk("t2_lock_after", lock_o, 1);

        // toggle at cnt 3 with DIV_PHASE_CNT=2: phase 6 != 5
        start_run(8, 2, 3, 1'b1);
        wait_err(200, got);
        chk("t2b_err", got, 1);
        chk("t2b_code", err_code_o, 2);
        chk("t2b_lock", lock_o, 0);

        // DIV_N=10 locked, then one 6-cycle high phase
        start_run(10, 0, 0, 1'b0);
        wait_lock(200, got);
        chk("t3_lock", got, 1);
        m_stretch = 1'b1;
        wait_err(60, got);
        chk("t3_err", got, 1);
        chk("t3_code", err_code_o, 1);
        chk("t3_lock_drop", lock_o, 0);
        chk("t3_high", meas_high_o, 6);
        clr_err_in = 1'b1;
        @(negedge clk_in);
        clr_err_in = 1'b0;
        chk("t3_clr_err", {err_o, err_code_o}, 0);
        chk("t3_clr_state", dbg_state_o, 1);
        wait_lock(200, got);
        chk("t3_relock", got, 1);
        sb_run(2, 5, 60);

        // div clock stuck low: error TIMEOUT cycles after the detected fall,
        // which itself lands SYNC_STAGE+2 source cycles after the toggle
        m_stop_fall = 1'b1;
        for (int i = 0; (i < 40) && m_run; i++) @(negedge clk_in);
        chk("t4_stopped", m_run, 0);
        wait_err(1200, got);
        chk("t4_err", got, 1);
        chk("t4_tmo_cycles", cyc - m_fall_cyc, TIMEOUT + SYNC_STAGE + 2);
        chk("t4_code", err_code_o, 3);
        chk("t4_lock", lock_o, 0);

        // invalid configurations
        @(negedge clk_in);
        en_in = 1'b0;
        @(negedge clk_in);
        chk("t5_idle", {lock_o, err_o, err_code_o}, 0);
        cfg_case("t5_odd", 7, 0);
        cfg_case("t5_one", 1, 0);
        cfg_case("t5_phase", 8, 4);

        // async reset while locked at DIV_N=16, then full reacquisition
        start_run(16, 0, 0, 1'b0);
        wait_lock(300, got);
        chk("t6_lock", got, 1);
        m_fall_seen = 1'b0;
        for (int i = 0; (i < 40) && !m_fall_seen; i++) @(negedge clk_in);
        chk("t6_fall", m_fall_seen, 1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("t6_rst_status", {lock_o, err_o, err_code_o}, 0);
        chk("t6_rst_meas", {meas_high_o, meas_low_o, meas_vld_o}, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        wait_lock(300, got);
        chk("t6_relock", got, 1);
        chk("t6_high", meas_high_o, 8);
        sb_run(2, 8, 100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
